// File: rtl/vx_csr_hpm.sv
// Programmable hardware performance-monitor CSR bank: NUM_CTRS event counters
// with event select, inhibit, sticky overflow and atomic split 64-bit reads.
module vx_csr_hpm #(
  parameter int unsigned NUM_CTRS      = 8,
  parameter int unsigned CTR_WIDTH     = 44,
  parameter int unsigned NUM_EVENTS    = 16,
  parameter int unsigned INC_BITS      = 4,
  parameter int unsigned CSR_ADDR_BITS = 12,
  parameter logic [CSR_ADDR_BITS-1:0] CTR_BASE     = 12'hB03,
  parameter logic [CSR_ADDR_BITS-1:0] CTR_BASE_H   = 12'hB83,
  parameter logic [CSR_ADDR_BITS-1:0] EVSEL_BASE   = 12'h323,
  parameter logic [CSR_ADDR_BITS-1:0] INHIBIT_ADDR = 12'h320,
  parameter logic [CSR_ADDR_BITS-1:0] OVF_ADDR     = 12'hBC0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_EVENTS*INC_BITS-1:0]   event_inc,
  input  logic                             read_enable,
  input  logic [CSR_ADDR_BITS-1:0]         read_addr,
  output logic                             read_valid,
  output logic [31:0]                      read_data,
  output logic                             read_addr_valid,
  input  logic                             write_enable,
  input  logic [CSR_ADDR_BITS-1:0]         write_addr,
  input  logic [31:0]                      write_data,
  output logic                             ovf_any
);

  localparam int unsigned EVSEL_BITS = $clog2(NUM_EVENTS);
  localparam int unsigned EVW        = EVSEL_BITS + 1;
  localparam int unsigned HI_BITS    = CTR_WIDTH - 32;
  localparam int unsigned SUM_W      = CTR_WIDTH + 1;
  localparam int unsigned IDX_BITS   = (NUM_CTRS > 1) ? $clog2(NUM_CTRS) : 1;

  logic [CTR_WIDTH-1:0]  ctr_q   [NUM_CTRS];
  logic [CTR_WIDTH-1:0]  ctr_n   [NUM_CTRS];
  logic [EVSEL_BITS-1:0] evsel_q [NUM_CTRS];
  logic [EVSEL_BITS-1:0] evsel_n [NUM_CTRS];
  logic [NUM_CTRS-1:0]   inhibit_q, inhibit_n;
  logic [NUM_CTRS-1:0]   ovf_q, ovf_n, ovf_set;

  logic [HI_BITS-1:0]    shadow_hi_q, shadow_hi_n;
  logic [IDX_BITS-1:0]   shadow_idx_q, shadow_idx_n;
  logic                  shadow_valid_q, shadow_valid_n;

  logic [INC_BITS-1:0]   ev_inc  [NUM_EVENTS];
  logic [INC_BITS-1:0]   inc_c   [NUM_CTRS];
  logic [SUM_W-1:0]      sum_c   [NUM_CTRS];
  logic [NUM_CTRS-1:0]   wr_lo_c, wr_hi_c, wr_ev_c;
  logic [31:0]           rd_data_c;
  logic                  rd_hit_c;

  // Unpack the flat event bus into per-event increments.
  always_comb begin
    for (int unsigned k = 0; k < NUM_EVENTS; k++) begin
      ev_inc[k] = event_inc[k*INC_BITS +: INC_BITS];
    end
  end

  // Per-counter selected increment, carry-extended sum and write-address decode.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CTRS; i++) begin
      inc_c[i] = '0;
      if (!inhibit_q[i] && (evsel_q[i] != '0) &&
          ({1'b0, evsel_q[i]} < EVW'(NUM_EVENTS))) begin
        inc_c[i] = ev_inc[evsel_q[i]];
      end
      sum_c[i]   = {1'b0, ctr_q[i]} + SUM_W'(inc_c[i]);
      wr_lo_c[i] = write_enable && (write_addr == CTR_BASE   + CSR_ADDR_BITS'(i));
      wr_hi_c[i] = write_enable && (write_addr == CTR_BASE_H + CSR_ADDR_BITS'(i));
      wr_ev_c[i] = write_enable && (write_addr == EVSEL_BASE + CSR_ADDR_BITS'(i));
    end
  end

  // Counter, event-select, inhibit and overflow next state.
  always_comb begin
    ctr_n     = ctr_q;
    evsel_n   = evsel_q;
    inhibit_n = inhibit_q;
    ovf_n     = ovf_q;
    ovf_set   = '0;
    for (int unsigned i = 0; i < NUM_CTRS; i++) begin
      if (wr_lo_c[i]) ctr_n[i][31:0] = write_data;
      if (wr_hi_c[i]) ctr_n[i][CTR_WIDTH-1:32] = HI_BITS'(write_data);
      // A software write to either half suppresses the whole increment.
      if (!wr_lo_c[i] && !wr_hi_c[i]) begin
        ctr_n[i]   = sum_c[i][CTR_WIDTH-1:0];
        ovf_set[i] = sum_c[i][CTR_WIDTH];
      end
      if (wr_ev_c[i]) evsel_n[i] = write_data[EVSEL_BITS-1:0];
    end
    if (write_enable && (write_addr == INHIBIT_ADDR)) inhibit_n = write_data[NUM_CTRS-1:0];
    if (write_enable && (write_addr == OVF_ADDR))     ovf_n     = ovf_q & ~write_data[NUM_CTRS-1:0];
    ovf_n = ovf_n | ovf_set;
  end

  // Read decode and high-half shadow for tear-free split reads.
  always_comb begin
    rd_data_c      = '0;
    rd_hit_c       = 1'b0;
    shadow_hi_n    = shadow_hi_q;
    shadow_idx_n   = shadow_idx_q;
    shadow_valid_n = shadow_valid_q;
    if (read_enable) begin
      for (int unsigned i = 0; i < NUM_CTRS; i++) begin
        if (read_addr == CTR_BASE + CSR_ADDR_BITS'(i)) begin
          rd_hit_c       = 1'b1;
          rd_data_c      = ctr_q[i][31:0];
          shadow_hi_n    = ctr_q[i][CTR_WIDTH-1:32];
          shadow_idx_n   = IDX_BITS'(i);
          shadow_valid_n = 1'b1;
        end
        if (read_addr == CTR_BASE_H + CSR_ADDR_BITS'(i)) begin
          rd_hit_c       = 1'b1;
          rd_data_c      = (shadow_valid_q && (shadow_idx_q == IDX_BITS'(i))) ?
                           32'(shadow_hi_q) : 32'(ctr_q[i][CTR_WIDTH-1:32]);
          shadow_valid_n = 1'b0;
        end
        if (read_addr == EVSEL_BASE + CSR_ADDR_BITS'(i)) begin
          rd_hit_c  = 1'b1;
          rd_data_c = 32'(evsel_q[i]);
        end
      end
      if (read_addr == INHIBIT_ADDR) begin
        rd_hit_c  = 1'b1;
        rd_data_c = 32'(inhibit_q);
      end
      if (read_addr == OVF_ADDR) begin
        rd_hit_c  = 1'b1;
        rd_data_c = 32'(ovf_q);
      end
    end
    for (int unsigned i = 0; i < NUM_CTRS; i++) begin
      if ((wr_lo_c[i] || wr_hi_c[i]) && (shadow_idx_n == IDX_BITS'(i))) shadow_valid_n = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_CTRS; i++) begin
        ctr_q[i]   <= '0;
        evsel_q[i] <= '0;
      end
      inhibit_q       <= '0;
      ovf_q           <= '0;
      shadow_hi_q     <= '0;
      shadow_idx_q    <= '0;
      shadow_valid_q  <= 1'b0;
      read_valid      <= 1'b0;
      read_data       <= '0;
      read_addr_valid <= 1'b0;
      ovf_any         <= 1'b0;
    end else begin
      ctr_q           <= ctr_n;
      evsel_q         <= evsel_n;
      inhibit_q       <= inhibit_n;
      ovf_q           <= ovf_n;
      shadow_hi_q     <= shadow_hi_n;
      shadow_idx_q    <= shadow_idx_n;
      shadow_valid_q  <= shadow_valid_n;
      read_valid      <= read_enable;
      read_data       <= rd_data_c;
      read_addr_valid <= rd_hit_c;
      ovf_any         <= |ovf_n;
    end
  end

endmodule
